bios_sink: RTL and testbench
============================

BIOS_SINK -- requirements
Module: bios_sink

Interface
REQ-001 Parameter WORDS, default 8192: number of 16-bit words in a full BIOS image.
REQ-002 Parameter FIFO_DEPTH, default 8: word buffer entries, power of two, at least 4.
REQ-003 Parameter BASE_ADDR, default 21'h07_E000: memory word address of BIOS word 0.
REQ-004 Port clk_sdr, input, 1: sole clock, rising edge.
REQ-005 Port reset_n, input, 1: reset is asynchronous and active-low.
REQ-006 Port bios_req, output, 1: sink can accept BIOS words.
REQ-007 Port bios_addr, input, 13: word index from the source.
REQ-008 Port bios_din, input, 16: data word, little-endian (low byte = even byte).
REQ-009 Port bios_wr, input, 1: write strobe, level; may be held high across several words.
REQ-010 Port mem_addr, output, 21: memory word address.
REQ-011 Port mem_dout, output, 16: memory write data.
REQ-012 Port mem_valid, output, 1: memory write request.
REQ-013 Port mem_ready, input, 1: memory accepts the request on this edge when mem_valid=1.
REQ-014 Port bios_loaded, output, 1: image fully written to memory; sticky.
REQ-015 Port err_seq, output, 1: sticky flag for an out-of-sequence source address.

Function
REQ-016 States and transitions:
- IDLE goes to LOAD one cycle after reset release.
- LOAD goes to DRAIN when the accepted-word count reaches WORDS.
- DRAIN goes to DONE when the FIFO is empty and no memory request is outstanding.
- DONE is terminal until the next reset.
REQ-017 bios_req is registered; it is 1 only in LOAD with FIFO occupancy at most FIFO_DEPTH-2.
REQ-018 A word is accepted in a cycle when all of these hold:
- bios_wr=1 and bios_req=1;
- and either bios_wr was 0 in the previous cycle, or bios_addr differs from the last accepted address.
REQ-019 Each accepted word pushes {BASE_ADDR+bios_addr, bios_din} into the FIFO and increments a 14-bit accepted-word count.
REQ-020 Address arithmetic is 21-bit unsigned; bios_addr is zero-extended.
REQ-021 The expected address starts at 0 and increments per accepted word; a mismatch sets err_seq, and the word is still stored at its given address.
REQ-022 Writes while bios_req=0, or in IDLE, DRAIN or DONE, are ignored and change no state.
REQ-023 Memory port:
- mem_valid/mem_addr/mem_dout come from the FIFO head, registered.
- They hold stable while mem_valid=1 and mem_ready=0.
- The head pops on mem_valid & mem_ready.
REQ-024 Latency: at most 2 cycles from acceptance to mem_valid with an empty FIFO and mem_ready=1.
REQ-025 Push and pop in the same cycle leave occupancy unchanged.
REQ-026 Pushing into a full FIFO is impossible by construction; simulation asserts on it.
REQ-027 bios_loaded goes to 1 on entry to DONE; bios_req stays 0 from then on.
REQ-028 Throughput: sustained 1 word/cycle when mem_ready is held at 1.

Reset
REQ-029 Reset values: bios_req=0, mem_valid=0, mem_addr=0, mem_dout=0, bios_loaded=0, err_seq=0; FIFO empty; counts 0; state IDLE.
REQ-030 Reset asserted mid-LOAD or mid-DRAIN discards buffered words; on release the load restarts from word 0.

Configuration
REQ-031 Macro BIOS_SINK_CHECKSUM_EN, when defined, adds:
- output bios_sum[15:0], the modulo-2^16 sum of accepted words, reset 0;
- input sum_expect[15:0];
- output sum_ok, set in DONE when bios_sum equals sum_expect, reset 0.
REQ-032 Without BIOS_SINK_CHECKSUM_EN these ports and the adder do not exist, and all other behaviour is identical.

Structure
REQ-033 Package bios_sink_pkg holds:
- the state enum (IDLE, LOAD, DRAIN, DONE);
- the default WORDS, FIFO_DEPTH and BASE_ADDR constants;
- the memory address width constant (21).
REQ-034 The FIFO is a separate sub-module bios_sink_fifo:
- synchronous, single clock, parameterised width and depth;
- provides push, pop, full, empty and level outputs.

Verification
REQ-035 Stream 8192 words, address 0..8191, data = address XOR 16'hA5A5, mem_ready=1 → 8192 memory writes at 07E000..07FFFF with matching data; bios_loaded=1; err_seq=0.
REQ-036 bios_wr held high while address changes every 2 cycles → exactly one write per address; no duplicates.
REQ-037 mem_ready=0 for 40 cycles during load → bios_req falls once occupancy reaches 7; no word is lost; mem_* stay stable while stalled.
REQ-038 Source sends addresses 0,1,3 → err_seq=1 after the third word; the third word is written at 07E003.
REQ-039 reset_n pulsed low after 100 words → all outputs return to reset values; a full reload then completes with bios_loaded=1.
REQ-040 With BIOS_SINK_CHECKSUM_EN, 8192 words of 16'h0001 and sum_expect=16'h2000 → sum_ok=1; with sum_expect=16'h1FFF → sum_ok=0.

Source files
------------

// File: rtl/bios_sink_pkg.sv
// rtl/bios_sink_pkg.sv - shared state enum, defaults and memory request type for bios_sink
package bios_sink_pkg;

  localparam int unsigned WORDS_DEF      = 8192;
  localparam int unsigned FIFO_DEPTH_DEF = 8;
  localparam int unsigned MEM_AW         = 21;
  localparam logic [MEM_AW-1:0] BASE_ADDR_DEF = 21'h07_E000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [15:0]       data;
  } mem_req_t;

  function automatic logic [MEM_AW-1:0] word_addr(input logic [MEM_AW-1:0] base,
                                                  input logic [12:0] idx);
    return base + {{(MEM_AW-13){1'b0}}, idx};
  endfunction

endpackage

// File: rtl/bios_sink_fifo.sv
// rtl/bios_sink_fifo.sv - single-clock synchronous word FIFO with occupancy level
module bios_sink_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q;

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push_i) - LW'(pop_i);
    end
  end

  // Storage needs no reset: only entries behind a valid level are ever read.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (!(push_i && full_o && !pop_i));
  end

endmodule

// File: rtl/bios_sink.sv
// rtl/bios_sink.sv - BIOS word sink: dedups source strobes, buffers, writes image to memory
// Optional running checksum of accepted words under BIOS_SINK_CHECKSUM_EN.
module bios_sink
  import bios_sink_pkg::*;
#(
  parameter int unsigned       WORDS      = WORDS_DEF,
  parameter int unsigned       FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter logic [MEM_AW-1:0] BASE_ADDR  = BASE_ADDR_DEF
) (
  input  logic              clk_sdr,
  input  logic              reset_n,
  output logic              bios_req,
  input  logic [12:0]       bios_addr,
  input  logic [15:0]       bios_din,
  input  logic              bios_wr,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_dout,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              bios_loaded,
  output logic              err_seq
`ifdef BIOS_SINK_CHECKSUM_EN
  ,
  output logic [15:0]       bios_sum,
  input  logic [15:0]       sum_expect,
  output logic              sum_ok
`endif
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  state_e      state_q, state_d;
  logic        bios_req_q, bios_req_d;
  logic        wr_prev_q;
  logic        have_last_q;
  logic [12:0] last_addr_q;
  logic [12:0] exp_addr_q;
  logic [13:0] count_q, count_d;
  logic        err_seq_q, err_seq_d;
  logic        loaded_q;
  mem_req_t    out_q, out_d;
  logic        mem_valid_q, mem_valid_d;

  logic        accept;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level, level_next;
  mem_req_t    push_word, head_word;

  // A held strobe re-presents the same word; only a fresh strobe or a new address counts.
  assign accept = (state_q == LOAD) && bios_req_q && bios_wr &&
                  (!wr_prev_q || !have_last_q || (bios_addr != last_addr_q));

  assign push_word.addr = word_addr(BASE_ADDR, bios_addr);
  assign push_word.data = bios_din;

  assign count_d    = count_q + 14'(accept);
  assign fifo_pop   = !fifo_empty && (!mem_valid_q || mem_ready);
  assign level_next = fifo_level + LW'(accept) - LW'(fifo_pop);
  assign err_seq_d  = err_seq_q || (accept && (bios_addr != exp_addr_q));

  bios_sink_fifo #(
    .WIDTH ($bits(mem_req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_sdr),
    .rst_ni      (reset_n),
    .push_i      (accept),
    .push_data_i (push_word),
    .pop_i       (fifo_pop),
    .head_o      (head_word),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .level_o     (fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    out_d       = out_q;

    case (state_q)
      IDLE:    state_d = LOAD;
      LOAD:    if (count_d == 14'(WORDS)) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !mem_valid_q) state_d = DONE;
      default: state_d = DONE;
    endcase

    // Looking at next-cycle occupancy keeps one free slot for the word a source may present
    // in the same cycle bios_req is seen high.
    bios_req_d = (state_d == LOAD) && !fifo_full && (level_next <= LW'(FIFO_DEPTH - 2));

    if (fifo_pop) begin
      mem_valid_d = 1'b1;
      out_d       = head_word;
    end else if (mem_ready) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sdr or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bios_req_q  <= 1'b0;
      wr_prev_q   <= 1'b0;
      have_last_q <= 1'b0;
      last_addr_q <= '0;
      exp_addr_q  <= '0;
      count_q     <= '0;
      err_seq_q   <= 1'b0;
      loaded_q    <= 1'b0;
      out_q       <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bios_req_q <= bios_req_d;
      wr_prev_q  <= bios_wr;
      if (accept) begin
        have_last_q <= 1'b1;
        last_addr_q <= bios_addr;
        exp_addr_q  <= exp_addr_q + 13'd1;
      end
      count_q     <= count_d;
      err_seq_q   <= err_seq_d;
      loaded_q    <= loaded_q || (state_d == DONE);
      out_q       <= out_d;
      mem_valid_q <= mem_valid_d;
    end
  end

  assign bios_req    = bios_req_q;
  assign mem_addr    = out_q.addr;
  assign mem_dout    = out_q.data;
  assign mem_valid   = mem_valid_q;
  assign bios_loaded = loaded_q;
  assign err_seq     = err_seq_q;

`ifdef BIOS_SINK_CHECKSUM_EN
  logic [15:0] sum_q;
  logic        sum_ok_q;

  always_ff @(posedge clk_sdr or negedge reset_n) begin
    if (!reset_n) begin
      sum_q    <= '0;
      sum_ok_q <= 1'b0;
    end else begin
      if (accept) sum_q <= sum_q + bios_din;
      sum_ok_q <= (state_q == DONE) && (sum_q == sum_expect);
    end
  end

  assign bios_sum = sum_q;
  assign sum_ok   = sum_ok_q;
`endif

endmodule

// File: tb/tb_bios_sink.sv
// tb/tb_bios_sink.sv - randomized self-checking bench for bios_sink against a word-level model
module tb_bios_sink;

  localparam int          WORDS = 8192;
  localparam logic [20:0] BASE  = 21'h07_E000;

  logic        clk_sdr = 1'b0;
  logic        reset_n;
  logic        bios_req;
  logic [12:0] bios_addr;
  logic [15:0] bios_din;
  logic        bios_wr;
  logic [20:0] mem_addr;
  logic [15:0] mem_dout;
  logic        mem_valid;
  logic        mem_ready;
  logic        bios_loaded;
  logic        err_seq;
`ifdef BIOS_SINK_CHECKSUM_EN
  logic [15:0] bios_sum;
  logic [15:0] sum_expect;
  logic        sum_ok;
`endif

  bios_sink dut (
    .clk_sdr     (clk_sdr),
    .reset_n     (reset_n),
    .bios_req    (bios_req),
    .bios_addr   (bios_addr),
    .bios_din    (bios_din),
    .bios_wr     (bios_wr),
    .mem_addr    (mem_addr),
    .mem_dout    (mem_dout),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .bios_loaded (bios_loaded),
    .err_seq     (err_seq)
`ifdef BIOS_SINK_CHECKSUM_EN
    ,
    .bios_sum    (bios_sum),
    .sum_expect  (sum_expect),
    .sum_ok      (sum_ok)
`endif
  );

  always #5 clk_sdr = ~clk_sdr;

  typedef struct packed {
    logic [12:0] a;
    logic [15:0] d;
  } word_t;

  word_t       tx_q[$];
  logic [36:0] exp_q[$];
  word_t       cur;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ready_pct = 100, stall_left = 0, gap_pct = 0, hold = 1, hold_left = 0;
  int n_acc = 0, nwr = 0, first_acc = -1, last_acc = -1, last_wr_cyc = -1;

  logic        prev_stall = 1'b0;
  logic [20:0] prev_addr = '0, last_wr_addr = '0;
  logic [15:0] prev_dout = '0;
  logic        m_prev_wr = 1'b0, m_have_last = 1'b0, m_err = 1'b0;
  logic [12:0] m_last = '0, m_exp = '0;

  task automatic model_clear();
    tx_q.delete();
    exp_q.delete();
    hold_left = 0; stall_left = 0; hold = 1; gap_pct = 0; ready_pct = 100;
    prev_stall = 1'b0;
    m_prev_wr = 1'b0; m_have_last = 1'b0; m_err = 1'b0; m_last = '0; m_exp = '0;
    n_acc = 0; nwr = 0; first_acc = -1; last_acc = -1; last_wr_cyc = -1;
  endtask

  // One clock: drive memory side, check the handshake the coming edge will perform,
  // then drive the source and predict acceptance from the source-side rules.
  task automatic tick();
    logic [36:0] e;
    logic        acc;
    @(negedge clk_sdr);
    cyc++;
    if (stall_left > 0) begin
      mem_ready = 1'b0;
      stall_left--;
    end else begin
      mem_ready = ($urandom_range(0, 99) < ready_pct);
    end
    if (prev_stall) begin
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== prev_addr || mem_dout !== prev_dout) begin
        errors++;
        $display("FAIL stall_hold: got valid=%b addr=%h data=%h, want valid=1 addr=%h data=%h",
                 mem_valid, mem_addr, mem_dout, prev_addr, prev_dout);
      end
    end
    if (mem_valid === 1'b1 && mem_ready) begin
      nwr++;
      last_wr_cyc  = cyc;
      last_wr_addr = mem_addr;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mem_write_extra: got addr=%h data=%h, want no write", mem_addr, mem_dout);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_dout} !== e) begin
          errors++;
          $display("FAIL mem_write: got addr=%h data=%h, want addr=%h data=%h",
                   mem_addr, mem_dout, e[36:16], e[15:0]);
        end
      end
    end
    prev_stall = (mem_valid === 1'b1) && !mem_ready;
    prev_addr  = mem_addr;
    prev_dout  = mem_dout;

    if (hold_left == 0 && tx_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
      cur = tx_q.pop_front();
      hold_left = hold;
    end
    if (hold_left > 0) begin
      bios_wr = 1'b1; bios_addr = cur.a; bios_din = cur.d;
    end else begin
      bios_wr = 1'b0;
    end

    acc = bios_wr && (bios_req === 1'b1) && (n_acc < WORDS) &&
          (!m_prev_wr || !m_have_last || bios_addr != m_last);
    if (acc) begin
      exp_q.push_back({BASE + {8'd0, bios_addr}, bios_din});
      if (bios_addr != m_exp) m_err = 1'b1;
      m_exp = m_exp + 13'd1;
      m_last = bios_addr;
      m_have_last = 1'b1;
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    m_prev_wr = bios_wr;
    if (hold_left > 0) begin
      if (hold == 1) begin
        if (acc) hold_left = 0;
      end else begin
        hold_left--;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk_sdr);
    bios_wr = 1'b0;
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(negedge clk_sdr);
    reset_n = 1'b1;
  endtask

  task automatic wait_loaded(input int bound);
    for (int i = 0; i < bound && bios_loaded !== 1'b1; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bios_wr = 1'b0; bios_addr = '0; bios_din = '0; mem_ready = 1'b0;
    #12;
    checks++;
    if ({bios_req, mem_valid, mem_addr, mem_dout, bios_loaded, err_seq} !== '0) begin
      errors++;
      $display("FAIL reset_values: got req=%b valid=%b addr=%h data=%h loaded=%b err=%b, want all 0",
               bios_req, mem_valid, mem_addr, mem_dout, bios_loaded, err_seq);
    end
    @(negedge clk_sdr);
    reset_n = 1'b1;
    model_clear();
    for (int i = 0; i < 4 && bios_req !== 1'b1; i++) tick();
    checks++;
    if (bios_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_rise: got req=%b, want 1 within 4 cycles", bios_req);
    end
  endtask

  task automatic test_latency();
    word_t w;
    apply_reset();
    repeat (3) tick();
    w.a = 13'd0; w.d = 16'($urandom);
    tx_q.push_back(w);
    for (int i = 0; i < 10 && nwr < 1; i++) tick();
    checks++;
    if (nwr != 1 || first_acc < 0 || (last_wr_cyc - first_acc) > 2) begin
      errors++;
      $display("FAIL latency: got writes=%0d cycles=%0d, want 1 write within 2 cycles",
               nwr, last_wr_cyc - first_acc);
    end
  endtask

  task automatic test_seq_error();
    word_t w;
    apply_reset();
    for (int i = 0; i < 2; i++) begin
      w.a = 13'(i); w.d = 16'($urandom); tx_q.push_back(w);
    end
    repeat (8) tick();
    checks++;
    if (err_seq !== 1'b0 || nwr != 2) begin
      errors++;
      $display("FAIL seq_in_order: got err=%b writes=%0d, want err=0 writes=2", err_seq, nwr);
    end
    w.a = 13'd3; w.d = 16'($urandom); tx_q.push_back(w);
    repeat (8) tick();
    checks++;
    if (err_seq !== 1'b1) begin
      errors++;
      $display("FAIL seq_gap_err: got err=%b, want 1", err_seq);
    end
    checks++;
    if (nwr != 3 || last_wr_addr !== 21'h07_E003) begin
      errors++;
      $display("FAIL seq_gap_addr: got writes=%0d last_addr=%h, want 3 writes last_addr=07e003",
               nwr, last_wr_addr);
    end
  endtask

  task automatic test_hold_dup();
    word_t w;
    apply_reset();
    hold = 2;
    for (int i = 0; i < 64; i++) begin
      w.a = 13'(i); w.d = 16'($urandom); tx_q.push_back(w);
    end
    for (int i = 0; i < 400 && (tx_q.size() > 0 || hold_left > 0); i++) tick();
    repeat (6) tick();
    checks++;
    if (nwr != 64 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL hold_dup: got writes=%0d pending=%0d, want 64 writes 0 pending",
               nwr, exp_q.size());
    end
  endtask

  task automatic test_stall();
    word_t w;
    apply_reset();
    for (int i = 0; i < 200; i++) begin
      w.a = 13'(i); w.d = 16'($urandom); tx_q.push_back(w);
    end
    for (int i = 0; i < 100 && n_acc < 20; i++) tick();
    stall_left = 40;
    repeat (40) tick();
    checks++;
    if (bios_req !== 1'b0 || (n_acc - nwr) < 7 || (n_acc - nwr) > 8) begin
      errors++;
      $display("FAIL stall_backpressure: got req=%b buffered=%0d, want req=0 buffered 7..8",
               bios_req, n_acc - nwr);
    end
    ready_pct = 60;
    for (int i = 0; i < 2000 && (tx_q.size() > 0 || hold_left > 0 || exp_q.size() > 0); i++) tick();
    checks++;
    if (nwr != 200 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_no_loss: got writes=%0d pending=%0d, want 200 writes 0 pending",
               nwr, exp_q.size());
    end
  endtask

  task automatic test_full_stream();
    word_t w;
    int    wr_before;
    apply_reset();
    for (int i = 0; i < WORDS; i++) begin
      w.a = 13'(i); w.d = 16'(i) ^ 16'hA5A5; tx_q.push_back(w);
    end
    wait_loaded(9000);
    checks++;
    if (bios_loaded !== 1'b1 || nwr != WORDS || exp_q.size() != 0) begin
      errors++;
      $display("FAIL full_stream: got loaded=%b writes=%0d pending=%0d, want loaded=1 writes=8192",
               bios_loaded, nwr, exp_q.size());
    end
    checks++;
    if (err_seq !== 1'b0) begin
      errors++;
      $display("FAIL full_stream_err: got err=%b, want 0", err_seq);
    end
    checks++;
    if ((last_acc - first_acc) != WORDS - 1) begin
      errors++;
      $display("FAIL throughput: got %0d cycles for 8192 words, want 8191",
               last_acc - first_acc);
    end
    wr_before = nwr;
    hold = 3;
    for (int i = 0; i < 4; i++) begin
      w.a = 13'(i); w.d = 16'($urandom); tx_q.push_back(w);
    end
    repeat (20) tick();
    checks++;
    if (nwr != wr_before || bios_req !== 1'b0 || bios_loaded !== 1'b1) begin
      errors++;
      $display("FAIL done_ignore: got extra_writes=%0d req=%b loaded=%b, want 0 req=0 loaded=1",
               nwr - wr_before, bios_req, bios_loaded);
    end
  endtask

  task automatic test_reset_reload();
    word_t w;
    apply_reset();
    ready_pct = 70; gap_pct = 20;
    for (int i = 0; i < 300; i++) begin
      w.a = 13'(i); w.d = 16'($urandom); tx_q.push_back(w);
    end
    for (int i = 0; i < 1000 && n_acc < 100; i++) tick();
    @(negedge clk_sdr);
    reset_n = 1'b0;
    bios_wr = 1'b0;
    #1;
    checks++;
    if ({bios_req, mem_valid, mem_addr, mem_dout, bios_loaded, err_seq} !== '0) begin
      errors++;
      $display("FAIL midload_reset: got req=%b valid=%b addr=%h data=%h loaded=%b err=%b, want all 0",
               bios_req, mem_valid, mem_addr, mem_dout, bios_loaded, err_seq);
    end
    model_clear();
    @(negedge clk_sdr);
    reset_n = 1'b1;
    ready_pct = 70; gap_pct = 10;
    for (int i = 0; i < WORDS; i++) begin
      w.a = 13'(i); w.d = 16'($urandom); tx_q.push_back(w);
    end
    wait_loaded(20000);
    checks++;
    if (bios_loaded !== 1'b1 || nwr != WORDS || exp_q.size() != 0 || err_seq !== 1'b0) begin
      errors++;
      $display("FAIL reload: got loaded=%b writes=%0d pending=%0d err=%b, want loaded=1 writes=8192 err=0",
               bios_loaded, nwr, exp_q.size(), err_seq);
    end
  endtask

`ifdef BIOS_SINK_CHECKSUM_EN
  task automatic test_checksum();
    word_t w;
    apply_reset();
    sum_expect = 16'h2000;
    for (int i = 0; i < WORDS; i++) begin
      w.a = 13'(i); w.d = 16'h0001; tx_q.push_back(w);
    end
    wait_loaded(9000);
    repeat (2) tick();
    checks++;
    if (sum_ok !== 1'b1 || bios_sum !== 16'h2000) begin
      errors++;
      $display("FAIL checksum_match: got ok=%b sum=%h, want ok=1 sum=2000", sum_ok, bios_sum);
    end
    sum_expect = 16'h1FFF;
    repeat (2) tick();
    checks++;
    if (sum_ok !== 1'b0) begin
      errors++;
      $display("FAIL checksum_mismatch: got ok=%b, want 0", sum_ok);
    end
  endtask
`endif

  initial begin
`ifdef BIOS_SINK_CHECKSUM_EN
    sum_expect = 16'h0000;
`endif
    test_reset();
    test_latency();
    test_seq_error();
    test_hold_dup();
    test_stall();
    test_full_stream();
    test_reset_reload();
`ifdef BIOS_SINK_CHECKSUM_EN
    test_checksum();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
